// File: rtl/fp_pkg.sv
`default_nettype none
// ============================================================================
// Module  : fp_pkg
// Brief   : Shared types and constants for the sequential single-precision
//           floating-point multiplier.
// Revision: 1.0 - initial release
// ============================================================================
package fp_pkg;

   // Multiplier control states
   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_UNPACK = 3'd1,
      S_MUL    = 3'd2,
      S_NORM   = 3'd3,
      S_DONE   = 3'd4
   } state_t;

   localparam int          BIAS    = 127;
   localparam int          EXP_MAX = 255;
   localparam logic [31:0] QNAN    = 32'h7FC0_0000;
   localparam int          MANT_W  = 24;
   localparam int          PROD_W  = 48;

endpackage : fp_pkg
`default_nettype wire

// File: rtl/fp_mul_seq_if.sv
`default_nettype none
// ============================================================================
// Module  : fp_mul_seq_if
// Brief   : Operand/result handshake bundle for the sequential FP multiplier.
// Revision: 1.0 - initial release
// ============================================================================
interface fp_mul_seq_if;

   logic        in_valid;
   logic        in_ready;
   logic [31:0] a;
   logic [31:0] b;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] result;

   // Producer/consumer side (drives operands, accepts results)
   modport master (
      output in_valid, a, b, out_ready,
      input  in_ready, out_valid, result
   );

   // Multiplier side
   modport slave (
      input  in_valid, a, b, out_ready,
      output in_ready, out_valid, result
   );

endinterface : fp_mul_seq_if
`default_nettype wire

// File: rtl/fp_mul_special.sv
`default_nettype none
// ============================================================================
// Module  : fp_mul_special
// Brief   : Combinational operand classifier. Flags NaN, infinity and
//           zero/denormal cases and supplies the value that replaces the
//           arithmetic product when a flag is raised.
// Revision: 1.0 - initial release
// ============================================================================
module fp_mul_special
   import fp_pkg::*;
(
   input  wire logic [31:0] i_a,
   input  wire logic [31:0] i_b,
   output logic             o_special,
   output logic [31:0]      o_value
);

   logic w_sign;
   logic w_a_max, w_b_max, w_a_zero, w_b_zero;
   logic w_a_nan, w_b_nan, w_a_inf, w_b_inf;

   assign w_sign   = i_a[31] ^ i_b[31];
   assign w_a_max  = (i_a[30:23] == 8'(EXP_MAX));
   assign w_b_max  = (i_b[30:23] == 8'(EXP_MAX));
   // Denormals are flushed, so any zero exponent counts as zero
   assign w_a_zero = (i_a[30:23] == 8'd0);
   assign w_b_zero = (i_b[30:23] == 8'd0);
   assign w_a_nan  = w_a_max & (i_a[22:0] != 23'd0);
   assign w_b_nan  = w_b_max & (i_b[22:0] != 23'd0);
   assign w_a_inf  = w_a_max & (i_a[22:0] == 23'd0);
   assign w_b_inf  = w_b_max & (i_b[22:0] == 23'd0);

   // Priority: NaN (incl. inf*zero) over infinity over zero
   always_comb begin
      o_special = 1'b0;
      o_value   = 32'd0;
      if (w_a_nan || w_b_nan || (w_a_inf && w_b_zero) || (w_b_inf && w_a_zero)) begin
         o_special = 1'b1;
         o_value   = QNAN;
      end else if (w_a_inf || w_b_inf) begin
         o_special = 1'b1;
         o_value   = {w_sign, 8'hFF, 23'd0};
      end else if (w_a_zero || w_b_zero) begin
         o_special = 1'b1;
         o_value   = {w_sign, 31'd0};
      end
   end

endmodule : fp_mul_special
`default_nettype wire

// File: rtl/fp_mul_seq.sv
`default_nettype none
// ============================================================================
// Module  : fp_mul_seq
// Brief   : Sequential IEEE-754 single-precision multiplier. One shift-add
//           step per cycle, round-to-nearest-even, flush-to-zero, fixed
//           26-cycle latency from operand acceptance to result valid.
// Revision: 1.0 - initial release
// ============================================================================
module fp_mul_seq
   import fp_pkg::*;
(
   input  wire logic   clk,
   input  wire logic   rst,
   fp_mul_seq_if.slave bus
);

   localparam logic signed [9:0] c_bias_s    = 10'(BIAS);
   localparam logic signed [9:0] c_exp_max_s = 10'(EXP_MAX);
   localparam logic [4:0]        c_last_iter = 5'(MANT_W - 1);

   state_t                   r_state;
   logic                     r_in_ready;
   logic                     r_out_valid;
   logic [31:0]              r_result;
   logic [31:0]              r_a;
   logic [31:0]              r_b;
   logic                     r_sign;
   logic signed [9:0]        r_exp;
   logic [MANT_W-1:0]        r_ma;
   logic [MANT_W-1:0]        r_mb;
   logic [PROD_W-1:0]        r_acc;
   logic [4:0]               r_cnt;
   logic                     r_special;
   logic [31:0]              r_special_val;

   logic                     w_special;
   logic [31:0]              w_special_val;
   logic signed [9:0]        w_exp_n;
   logic signed [9:0]        w_exp_f;
   logic [22:0]              w_mant;
   logic                     w_guard;
   logic                     w_sticky;
   logic                     w_round_up;
   logic [23:0]              w_mant_r;
   logic [31:0]              w_norm_result;

   assign bus.in_ready  = r_in_ready;
   assign bus.out_valid = r_out_valid;
   assign bus.result    = r_result;

   fp_mul_special u_special (
      .i_a       (r_a),
      .i_b       (r_b),
      .o_special (w_special),
      .o_value   (w_special_val)
   );

   // Normalise, round to nearest-even and pack the finished product
   always_comb begin
      w_exp_n  = r_exp + (r_acc[PROD_W-1] ? 10'sd1 : 10'sd0);
      w_mant   = r_acc[45:23];
      w_guard  = r_acc[22];
      w_sticky = |r_acc[21:0];
      if (r_acc[PROD_W-1]) begin
         w_mant   = r_acc[46:24];
         w_guard  = r_acc[23];
         w_sticky = |r_acc[22:0];
      end
      w_round_up = w_guard & (w_sticky | w_mant[0]);
      w_mant_r   = {1'b0, w_mant} + {23'd0, w_round_up};
      // A carry out of the fraction leaves an all-zero fraction one binade up
      w_exp_f    = w_exp_n + (w_mant_r[23] ? 10'sd1 : 10'sd0);
      if (r_special) begin
         w_norm_result = r_special_val;
      end else if (w_exp_f >= c_exp_max_s) begin
         w_norm_result = {r_sign, 8'hFF, 23'd0};
      end else if (w_exp_f <= 10'sd0) begin
         w_norm_result = {r_sign, 31'd0};
      end else begin
         w_norm_result = {r_sign, w_exp_f[7:0], w_mant_r[23] ? 23'd0 : w_mant_r[22:0]};
      end
   end

   // Control FSM and datapath registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state       <= S_IDLE;
         r_in_ready    <= 1'b0;
         r_out_valid   <= 1'b0;
         r_result      <= 32'd0;
         r_a           <= 32'd0;
         r_b           <= 32'd0;
         r_sign        <= 1'b0;
         r_exp         <= 10'sd0;
         r_ma          <= '0;
         r_mb          <= '0;
         r_acc         <= '0;
         r_cnt         <= 5'd0;
         r_special     <= 1'b0;
         r_special_val <= 32'd0;
      end else begin
         case (r_state)
            S_IDLE: begin
               // in_ready comes up one cycle after reset release
               r_in_ready <= 1'b1;
               if (r_in_ready && bus.in_valid) begin
                  r_a        <= bus.a;
                  r_b        <= bus.b;
                  r_in_ready <= 1'b0;
                  r_state    <= S_UNPACK;
               end
            end
            S_UNPACK: begin
               r_sign        <= r_a[31] ^ r_b[31];
               r_exp         <= $signed({2'b00, r_a[30:23]}) + $signed({2'b00, r_b[30:23]}) - c_bias_s;
               r_ma          <= {1'b1, r_a[22:0]};
               r_mb          <= {1'b1, r_b[22:0]};
               r_acc         <= '0;
               r_cnt         <= 5'd0;
               r_special     <= w_special;
               r_special_val <= w_special_val;
               r_state       <= S_MUL;
            end
            S_MUL: begin
               // Multiplier is consumed LSB first; partial product weight is 2^cnt
               r_acc <= r_acc + (r_mb[0] ? (PROD_W'(r_ma) << r_cnt) : '0);
               r_mb  <= r_mb >> 1;
               if (r_cnt == c_last_iter) begin
                  r_cnt   <= 5'd0;
                  r_state <= S_NORM;
               end else begin
                  r_cnt <= r_cnt + 5'd1;
               end
            end
            S_NORM: begin
               r_result    <= w_norm_result;
               r_out_valid <= 1'b1;
               r_state     <= S_DONE;
            end
            S_DONE: begin
               if (bus.out_ready) begin
                  r_out_valid <= 1'b0;
                  r_in_ready  <= 1'b1;
                  r_state     <= S_IDLE;
               end
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

endmodule : fp_mul_seq
`default_nettype wire

// File: tb/tb_fp_mul_seq.sv
`default_nettype none
// ============================================================================
// Module  : tb_fp_mul_seq
// Brief   : Scoreboard testbench for fp_mul_seq. The driver pushes expected
//           products and acceptance times; the monitor checks every result,
//           its latency and its stability while stalled.
// Revision: 1.0 - initial release
// ============================================================================
module tb_fp_mul_seq;

   localparam int PERIOD  = 10;
   localparam int LATENCY = 26;

   logic clk = 1'b0;
   logic rst = 1'b0;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   logic [31:0] exp_q[$];
   int          acc_q[$];

   logic        ready_random = 1'b1;
   logic        ready_force  = 1'b0;
   logic        prev_valid   = 1'b0;
   logic [31:0] prev_result  = 32'd0;

   fp_mul_seq_if bus ();

   fp_mul_seq dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   always #(PERIOD/2) clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %h, required %h (t=%0t)", name, act, req, $time);
      end
   endtask

   task automatic bound_fail(input string name);
      n_checks++;
      n_fail++;
      $display("FAIL %s: bound expired (t=%0t)", name, $time);
   endtask

   // Reference product from the IEEE rules using integer arithmetic
   function automatic logic [31:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
      logic s;
      logic a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
      longint unsigned m, q, rem, half;
      int e, sh;
      logic [31:0] r;
      s      = a[31] ^ b[31];
      a_zero = (a[30:23] == 0);
      b_zero = (b[30:23] == 0);
      a_nan  = (a[30:23] == 255) && (a[22:0] != 0);
      b_nan  = (b[30:23] == 255) && (b[22:0] != 0);
      a_inf  = (a[30:23] == 255) && (a[22:0] == 0);
      b_inf  = (b[30:23] == 255) && (b[22:0] == 0);
      if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) return 32'h7FC00000;
      if (a_inf || b_inf) return {s, 8'hFF, 23'd0};
      if (a_zero || b_zero) return {s, 31'd0};
      m  = 64'({1'b1, a[22:0]}) * 64'({1'b1, b[22:0]});
      sh = (m >= (64'd1 << 47)) ? 24 : 23;
      e  = int'(a[30:23]) + int'(b[30:23]) - 127 + ((sh == 24) ? 1 : 0);
      q    = m >> sh;
      rem  = m - (q << sh);
      half = 64'd1 << (sh - 1);
      if (rem > half || (rem == half && q[0])) q = q + 1;
      if (q == (64'd1 << 24)) begin
         q = 64'd1 << 23;
         e = e + 1;
      end
      if (e >= 255) return {s, 8'hFF, 23'd0};
      if (e <= 0) return {s, 31'd0};
      r = {s, e[7:0], q[22:0]};
      return r;
   endfunction

   function automatic logic [31:0] rand_fp();
      logic [7:0]  e;
      logic [22:0] f;
      int          k;
      k = int'($urandom_range(0, 15));
      f = 23'($urandom);
      case (k)
         0:       e = 8'd0;
         1:       begin e = 8'hFF; f = 23'd0; end
         2:       begin e = 8'hFF; f = f | 23'd1; end
         3:       e = 8'($urandom_range(200, 254));
         4:       e = 8'($urandom_range(1, 60));
         default: e = 8'($urandom_range(64, 190));
      endcase
      return {1'($urandom_range(0, 1)), e, f};
   endfunction

   // Present operands until accepted, then log the expectation
   task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [31:0] expv);
      int waited;
      waited = 0;
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.a        = a;
      bus.b        = b;
      while (!bus.in_ready && waited < 300) begin
         @(negedge clk);
         waited++;
      end
      if (!bus.in_ready) begin
         bound_fail("send_accept");
         bus.in_valid = 1'b0;
         return;
      end
      exp_q.push_back(expv);
      acc_q.push_back(cyc);
      @(negedge clk);
      bus.in_valid = 1'b0;
      bus.a        = $urandom;
      bus.b        = $urandom;
   endtask

   // Consumer back-pressure, changed just after each rising edge
   initial begin
      bus.out_ready = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         bus.out_ready = ready_random ? ($urandom_range(0, 3) != 0) : ready_force;
      end
   end

   // Monitor: latency on each new result, stability while stalled, value on handoff
   always @(negedge clk) begin
      if (rst) begin
         prev_valid = 1'b0;
      end else begin
         if (bus.out_valid) begin
            check("in_ready_in_done", 32'(bus.in_ready), 32'd0);
            if (!prev_valid) begin
               if (acc_q.size() == 0) begin
                  bound_fail("unexpected_output");
               end else begin
                  // Sampled at the negedge before the accepting edge, so the first
                  // negedge showing out_valid is LATENCY+1 counts later
                  check("latency", 32'(cyc - acc_q.pop_front()), 32'(LATENCY + 1));
               end
            end else begin
               check("result_stable", bus.result, prev_result);
            end
            if (bus.out_ready) begin
               if (exp_q.size() == 0) bound_fail("scoreboard_empty");
               else check("result", bus.result, exp_q.pop_front());
            end
         end
         prev_valid  = bus.out_valid && !bus.out_ready;
         prev_result = bus.result;
      end
   end

   initial begin
      #(PERIOD * 40000);
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   logic [31:0] dv [0:9][0:2];
   int          waited;

   initial begin
      bus.in_valid = 1'b0;
      bus.a        = 32'd0;
      bus.b        = 32'd0;
      dv = '{
         '{32'h3FC00000, 32'h40000000, 32'h40400000},
         '{32'hC0000000, 32'h3F000000, 32'hBF800000},
         '{32'h3F800001, 32'h3F800001, 32'h3F800002},
         '{32'h7F800000, 32'h00000000, 32'h7FC00000},
         '{32'h7F000000, 32'h7F000000, 32'h7F800000},
         '{32'h00800000, 32'h00800000, 32'h00000000},
         '{32'h7F800000, 32'hC0000000, 32'hFF800000},
         '{32'h7FC00001, 32'h3F800000, 32'h7FC00000},
         '{32'h3F800001, 32'h3FC00000, 32'h3FC00002},
         '{32'h3F800003, 32'h3FC00000, 32'h3FC00004}
      };

      // Reset state
      #1 rst = 1'b1;
      #2;
      check("reset_in_ready", 32'(bus.in_ready), 32'd0);
      check("reset_out_valid", 32'(bus.out_valid), 32'd0);
      check("reset_result", bus.result, 32'd0);
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("in_ready_after_reset", 32'(bus.in_ready), 32'd1);

      // Directed vectors
      for (int i = 0; i < 10; i++) send(dv[i][0], dv[i][1], dv[i][2]);
      send(32'h00000001, 32'h3F800000, 32'h00000000);
      send(32'h80000000, 32'h3F800000, 32'h80000000);

      // Stall in DONE with new operands waiting
      waited = 0;
      while (exp_q.size() != 0 && waited < 200) begin @(negedge clk); waited++; end
      if (exp_q.size() != 0) bound_fail("drain_before_stall");
      @(negedge clk);
      ready_force  = 1'b0;
      ready_random = 1'b0;
      send(32'h3FC00000, 32'h40000000, 32'h40400000);
      fork
         send(32'h40400000, 32'h40000000, 32'h40C00000);
         begin
            waited = 0;
            while (!bus.out_valid && waited < 60) begin @(negedge clk); waited++; end
            if (!bus.out_valid) bound_fail("stall_out_valid");
            repeat (5) begin
               @(negedge clk);
               check("stall_in_ready", 32'(bus.in_ready), 32'd0);
            end
            ready_force = 1'b1;
            @(negedge clk);
            ready_force = 1'b0;
            @(negedge clk);
            check("idle_after_pulse_out_valid", 32'(bus.out_valid), 32'd0);
            check("idle_after_pulse_in_ready", 32'(bus.in_ready), 32'd1);
         end
      join
      ready_random = 1'b1;

      // Reset during the tenth multiply iteration
      waited = 0;
      while (exp_q.size() != 0 && waited < 200) begin @(negedge clk); waited++; end
      if (exp_q.size() != 0) bound_fail("drain_before_reset");
      send(32'h3FC00000, 32'h40000000, 32'h40400000);
      repeat (11) @(posedge clk);
      #2 rst = 1'b1;
      #1;
      check("abort_out_valid", 32'(bus.out_valid), 32'd0);
      check("abort_result", bus.result, 32'd0);
      check("abort_in_ready", 32'(bus.in_ready), 32'd0);
      exp_q.delete();
      acc_q.delete();
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("in_ready_after_abort", 32'(bus.in_ready), 32'd1);
      send(32'h3FC00000, 32'h40000000, 32'h40400000);

      // Randomised operands against the reference model
      for (int i = 0; i < 40; i++) begin
         logic [31:0] ra, rb;
         ra = rand_fp();
         rb = rand_fp();
         send(ra, rb, ref_mul(ra, rb));
      end

      waited = 0;
      while (exp_q.size() != 0 && waited < 300) begin @(negedge clk); waited++; end
      if (exp_q.size() != 0) bound_fail("final_drain");
      repeat (2) @(negedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule : tb_fp_mul_seq
`default_nettype wire

// File: doc/fp_mul_seq.md
FP_MUL_SEQ -- requirements
Module: fp_mul_seq

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-high reset.
REQ-002 Port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-003 Port rst, input, 1 bit: asynchronous reset, active-high.
REQ-004 Port in_valid, input, 1 bit: operands a/b are valid.
REQ-005 Port in_ready, output, 1 bit: block can accept operands.
REQ-006 Port a, input, 32 bits: IEEE-754 single multiplicand.
REQ-007 Port b, input, 32 bits: IEEE-754 single multiplier.
REQ-008 Port out_valid, output, 1 bit: result holds a valid product.
REQ-009 Port out_ready, input, 1 bit: consumer accepts the result.
REQ-010 Port result, output, 32 bits: IEEE-754 single product.

Function
REQ-011 The FSM SHALL have the states IDLE, UNPACK, MUL, NORM and DONE.
REQ-012 in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in DONE.
REQ-013 IDLE: when in_valid=1, the block SHALL capture a and b, then move to UNPACK; otherwise it stays in IDLE.
REQ-014 UNPACK (1 cycle): the block SHALL compute sign = a[31]^b[31] and exp = a[30:23] + b[30:23] - 127 in 10-bit signed arithmetic.
REQ-015 UNPACK SHALL form the 24-bit mantissas with hidden bit 1, clear the 48-bit accumulator and the 5-bit iteration counter, and move to MUL.
REQ-016 MUL: each cycle is one radix-2 shift-add step on the 48-bit product; after exactly 24 iterations the block SHALL move to NORM; the counter SHALL wrap to 0 on exit.
REQ-017 NORM (1 cycle): if product[47]=1, take mantissa from [46:24], exp+1, guard=[23], sticky=|[22:0]; otherwise take mantissa from [45:23], guard=[22], sticky=|[21:0].
REQ-018 NORM SHALL round to nearest, ties to even; if rounding carries out of the mantissa, exp+1 and mantissa=0.
REQ-019 NORM SHALL then pack result and move to DONE.
REQ-020 Latency SHALL be fixed: out_valid rises exactly 26 rising edges after the edge that accepted in_valid, regardless of operand class.
REQ-021 DONE SHALL hold result and out_valid stable until out_ready=1 at an edge, then return to IDLE.
REQ-022 New operands SHALL be accepted no earlier than the following cycle; in_valid is ignored outside IDLE.
REQ-023 Special case: if either input is NaN (exp=255, frac!=0), or inf*zero, result = 32'h7FC00000.
REQ-024 Special case: inf * finite-nonzero SHALL give signed infinity.
REQ-025 Special case: a zero or denormal input (exp=0) SHALL be flushed and give signed zero.
REQ-026 Overflow: final exp >= 255 SHALL give signed infinity (exp=255, frac=0).
REQ-027 Underflow: final exp <= 0 SHALL give signed zero; no denormal outputs are produced.
REQ-028 Special-case classification SHALL be done in UNPACK and registered as a flag; the result override is applied in NORM.

Reset
REQ-029 On rst=1, the block SHALL asynchronously go to IDLE and clear the counter, accumulator and flags.
REQ-030 During reset: in_ready=0, out_valid=0, result=32'h0; in_ready goes to 1 on the first cycle after reset deasserts.
REQ-031 A reset in any state, including mid-MUL or DONE, SHALL abort the operation; no partial result is ever presented.

Structure
REQ-032 Shared package fp_pkg SHALL hold: the FSM state enum, BIAS=127, EXP_MAX=255, QNAN=32'h7FC00000, MANT_W=24 and PROD_W=48.
REQ-033 A combinational sub-module fp_mul_special SHALL classify operands and output the special-case flags and override value.

Verification
REQ-034 a=0x3FC00000, b=0x40000000, in_valid pulse -> after 26 edges, out_valid=1 with result=0x40400000.
REQ-035 a=0xC0000000, b=0x3F000000 -> result=0xBF800000; a=0x3F800001, b=0x3F800001 -> result=0x3F800002 (rounding).
REQ-036 a=0x7F800000, b=0x00000000 -> result=0x7FC00000; a=0x7F000000, b=0x7F000000 -> result=0x7F800000; a=0x00800000, b=0x00800000 -> result=0x00000000.
REQ-037 out_ready held 0 for 5 cycles in DONE while in_valid=1 with new operands -> result stable, in_ready=0; after the out_ready pulse, IDLE, then the new operands are accepted.
REQ-038 rst pulsed at iteration 10 of MUL -> out_valid=0, result=0 immediately; a subsequent 1.5*2.0 returns 0x40400000 with full 26-edge latency.
